instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the immediate generator: packs decoded fields plus a 64-bit immediate
//  into a 32-bit RV64 instruction word for R, I, S and SB formats.
//  Sits between the test/boot sequencer and instruction memory write port.
//  1-deep valid/ready pipeline with range checking and encode/error counters.
// PARAMETERS
//  CNT_W   16  width of enc_count and err_count
// PORTS
//  clk        in   1   clock, all state on rising edge
//  rst_n      in   1   asynchronous active-low reset
//  in_valid   in   1   request valid
//  in_ready   out  1   request accepted when in_valid && in_ready
//  in_type    in   2   format: 0=R, 1=I, 2=S, 3=SB
//  in_opcode  in   7   opcode, used for I only (LOAD/OP-IMM/JALR)
//  in_rd      in   5   destination reg (R, I)
//  in_rs1     in   5   source reg 1 (all formats)
//  in_rs2     in   5   source reg 2 (R, S, SB)
//  in_funct3  in   3   funct3 (all formats)
//  in_funct7  in   7   funct7 (R only)
//  in_imm     in   64  sign-extended immediate (I, S, SB); byte offset for SB
//  out_valid  out  1   encoded word valid
//  out_ready  in   1   consumer accepts when out_valid && out_ready
//  out_instr  out  32  encoded instruction
//  out_err    out  1   immediate out of range / misaligned; out_instr is NOP
//  cnt_clr    in   1   synchronous clear of both counters
//  enc_count  out  CNT_W  handshaked outputs, wraps
//  err_count  out  CNT_W  handshaked outputs with out_err=1, saturates at all-ones
// BEHAVIOUR
//  Reset: out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0.
//  in_ready = !out_valid || out_ready (combinational); latency 1 cycle, throughput 1/clk.
//  Accept + output handshake in same cycle: register reloads, out_valid stays 1.
//  out_valid && !out_ready: out_instr/out_err held stable, no new accept.
//  Encoding:
//   R : {funct7, rs2, rs1, funct3, rd, 7'b0110011}
//   I : {imm[11:0], rs1, funct3, rd, in_opcode}
//   S : {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}
//   SB: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}
//  Range: I/S legal iff in_imm[63:11] all equal; SB legal iff in_imm[63:12] all equal
//   and in_imm[0]=0. R ignores in_imm.
//  Illegal: out_instr=32'h00000013 (ADDI x0,x0,0), out_err=1. Legal: out_err=0.
//  Counters update on out_valid && out_ready. cnt_clr has priority over increment.
//  enc_count wraps at all-ones; err_count saturates.
//  Async reset mid-transfer drops the held word; no output until next accept.
// TESTING
//  R add rd=3 rs1=1 rs2=2 f3=0 f7=0 -> out_instr=32'h002081B3 one cycle later, err=0.
//  I op=0010011 rd=1 rs1=2 f3=0 imm=-1 -> 32'hFFF10093; imm=2048 -> 32'h00000013, err=1.
//  S rs1=2 rs2=5 f3=3 imm=16 -> 32'h00513823; SB rs1=1 rs2=2 f3=0 imm=-8 -> 32'hFE208CE3.
//  SB imm=5 (odd) and imm=4096 -> NOP with err=1 each; err_count increments to 2.
//  Hold out_ready=0 for 3 cycles with in_valid=1: in_ready=0, out_instr stable, counters frozen.
//  Stream 4 words with out_ready=1: one word/cycle, enc_count=4; cnt_clr -> 0 next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// RV64 instruction packer: folds decoded fields and a 64-bit immediate back into a 32-bit
// R/I/S/SB word behind a 1-deep valid/ready register, with encode and error counters.
module instr_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_type,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [63:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {FmtR = 2'd0, FmtI = 2'd1, FmtS = 2'd2, FmtSb = 2'd3} fmt_e;

  localparam logic [6:0]  OpReg    = 7'b0110011;
  localparam logic [6:0]  OpStore  = 7'b0100011;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [31:0] Nop      = 32'h0000_0013;

  logic             imm_fits12;
  logic             imm_fits13;
  logic [31:0]      enc_word;
  logic             enc_legal;
  logic [31:0]      enc_instr;
  logic             accept;
  logic             fire;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  // The immediate fits iff every bit above the field's sign bit copies it.
  assign imm_fits12 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
  assign imm_fits13 = (&in_imm[63:12]) | ~(|in_imm[63:12]);

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    unique case (fmt_e'(in_type))
      FmtR: begin
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OpReg};
      end
      FmtI: begin
        enc_legal = imm_fits12;
        enc_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      FmtS: begin
        enc_legal = imm_fits12;
        enc_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OpStore};
      end
      FmtSb: begin
        enc_legal = imm_fits13 & ~in_imm[0];
        enc_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                     in_imm[11], OpBranch};
      end
      default: begin
        enc_word  = '0;
        enc_legal = 1'b1;
      end
    endcase
    enc_instr = enc_legal ? enc_word : Nop;
  end

  assign in_ready = ~out_valid_q | out_ready;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid_q & out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_err_d   = out_err_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_instr_d = enc_instr;
      out_err_d   = ~enc_legal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (cnt_clr) begin
      enc_count_d = '0;
      err_count_d = '0;
    end else if (fire) begin
      enc_count_d = enc_count_q + CNT_W'(1);
      if (out_err_q && !(&err_count_q)) begin
        err_count_d = err_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_err_q   <= 1'b0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_err_q   <= out_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_err   = out_err_q;
  assign enc_count = enc_count_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed encodings, stall/stream/reset scenarios and a randomized
// run against an arithmetic reference model. Narrow counters make wrap/saturation reachable.
module tb_instr_encoder;

  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, out_valid, out_ready, out_err, cnt_clr;
  logic [1:0]    in_type;
  logic [6:0]    in_opcode, in_funct7;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [2:0]    in_funct3;
  logic [63:0]   in_imm;
  logic [31:0]   out_instr;
  logic [CW-1:0] enc_count, err_count;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err), .cnt_clr(cnt_clr),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Reference encoding from signed-range arithmetic and shifted bit-fields: {err, word}.
  function automatic logic [32:0] model_encode(input logic [1:0] t, input logic [6:0] op,
      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm);
    longint s, w, com;
    bit ok;
    s   = longint'(imm);
    ok  = 1'b1;
    com = (longint'(rs1) << 15) | (longint'(f3) << 12);
    case (t)
      2'd0: w = (longint'(f7) << 25) | (longint'(rs2) << 20) | com | (longint'(rd) << 7) | 'h33;
      2'd1: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = ((s & 'hFFF) << 20) | com | (longint'(rd) << 7) | longint'(op);
      end
      2'd2: begin
        ok = (s >= -2048) && (s <= 2047);
        w  = (((s >> 5) & 'h7F) << 25) | (longint'(rs2) << 20) | com | ((s & 'h1F) << 7) | 'h23;
      end
      default: begin
        ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
        w  = (((s >> 12) & 1) << 31) | (((s >> 5) & 'h3F) << 25) | (longint'(rs2) << 20) | com
           | (((s >> 1) & 'hF) << 8) | (((s >> 11) & 1) << 7) | 'h63;
      end
    endcase
    if (!ok) w = 'h13;
    return {!ok, w[31:0]};
  endfunction

  // Transaction-level model of the output slot and counters.
  logic [32:0] m_next;
  logic        m_valid;
  logic [31:0] m_instr;
  logic        m_err;
  int          m_enc, m_errc;

  assign m_next = model_encode(in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
                               in_imm);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_instr <= '0;
      m_err   <= 1'b0;
      m_enc   <= 0;
      m_errc  <= 0;
    end else begin
      if (cnt_clr) begin
        m_enc  <= 0;
        m_errc <= 0;
      end else if (m_valid && out_ready) begin
        m_enc  <= (m_enc + 1) % (CMAX + 1);
        m_errc <= (m_err && m_errc < CMAX) ? m_errc + 1 : m_errc;
      end
      if (in_valid && (!m_valid || out_ready)) begin
        m_valid <= 1'b1;
        m_instr <= m_next[31:0];
        m_err   <= m_next[32];
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  task automatic set_req(input logic [1:0] t, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [63:0] imm);
    in_valid  = 1'b1;
    in_type   = t;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
  endtask

  function automatic logic [63:0] rand_imm(input logic [1:0] t);
    longint edges[9];
    edges = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097};
    case ($urandom_range(0, 4))
      0: return 64'(longint'($urandom_range(0, 4095)) - 2048);
      1: return 64'(longint'($urandom_range(0, 8191)) - 4096);
      2: return 64'(edges[$urandom_range(0, 8)]);
      3: return {$urandom, $urandom};
      default: return (t == 2'd3) ? 64'(2 * (longint'($urandom_range(0, 4095)) - 2048))
                                  : 64'(longint'($urandom_range(0, 4095)) - 2048);
    endcase
  endfunction

  task automatic drain_and_clear();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    total += 6;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    if (out_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    if (out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", out_err); end
    if (enc_count !== '0) begin bad++; $display("FAIL reset_enc got=%0d exp=0", enc_count); end
    if (err_count !== '0) begin bad++; $display("FAIL reset_errc got=%0d exp=0", err_count); end
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_directed();
    logic [1:0]  ty[7] = '{0, 1, 1, 2, 3, 3, 3};
    logic [4:0]  rd[7] = '{3, 1, 1, 0, 0, 0, 0};
    logic [4:0]  r1[7] = '{1, 2, 2, 2, 1, 1, 1};
    logic [4:0]  r2[7] = '{2, 0, 0, 5, 2, 2, 2};
    logic [2:0]  f3[7] = '{0, 0, 0, 3, 0, 0, 0};
    longint      im[7] = '{0, -1, 2048, 16, -8, 5, 4096};
    logic [31:0] ew[7] = '{32'h002081B3, 32'hFFF10093, 32'h13, 32'h00513823, 32'hFE208CE3,
                           32'h13, 32'h13};
    logic        ee[7] = '{0, 0, 1, 0, 0, 1, 1};
    drain_and_clear();
    for (int i = 0; i < 7; i++) begin
      set_req(ty[i], 7'b0010011, rd[i], r1[i], r2[i], f3[i], 7'd0, 64'(im[i]));
      @(posedge clk);
      #1;
      total += 2;
      if (out_instr !== ew[i]) begin
        bad++; $display("FAIL directed_instr[%0d] got=%h exp=%h", i, out_instr, ew[i]);
      end
      if (out_err !== ee[i]) begin
        bad++; $display("FAIL directed_err[%0d] got=%b exp=%b", i, out_err, ee[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_err_count();
    drain_and_clear();
    total += 2;
    if (enc_count !== '0) begin bad++; $display("FAIL clr_enc got=%0d exp=0", enc_count); end
    if (err_count !== '0) begin bad++; $display("FAIL clr_errc got=%0d exp=0", err_count); end
    set_req(2'd3, 7'd0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd5);
    @(posedge clk);
    #1 set_req(2'd3, 7'd0, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 64'd4096);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    total += 2;
    if (err_count !== 4'd2) begin bad++; $display("FAIL errc_two got=%0d exp=2", err_count); end
    if (enc_count !== 4'd2) begin bad++; $display("FAIL enc_two got=%0d exp=2", enc_count); end
  endtask

  task automatic test_stall();
    drain_and_clear();
    set_req(2'd0, 7'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
    @(posedge clk);
    #1 out_ready = 1'b0;
    set_req(2'd0, 7'd0, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      total += 4;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, in_ready); end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, out_valid); end
      if (out_instr !== 32'h002081B3) begin
        bad++; $display("FAIL stall_instr[%0d] got=%h exp=002081b3", i, out_instr);
      end
      if (enc_count !== '0) begin bad++; $display("FAIL stall_enc[%0d] got=%0d exp=0", i, enc_count); end
      @(posedge clk);
    end
    #1 out_ready = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL release_ready got=%b exp=1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    total += 2;
    if (out_instr !== 32'h00208233) begin
      bad++; $display("FAIL release_instr got=%h exp=00208233", out_instr);
    end
    if (enc_count !== 4'd1) begin bad++; $display("FAIL release_enc got=%0d exp=1", enc_count); end
  endtask

  task automatic test_back_to_back();
    logic [32:0] exp_w;
    drain_and_clear();
    for (int i = 0; i < 4; i++) begin
      set_req(2'($urandom_range(0, 3)), 7'h13, 5'($urandom), 5'($urandom), 5'($urandom),
              3'($urandom), 7'($urandom), 64'(longint'($urandom_range(0, 2047)) * 2 - 2048));
      exp_w = model_encode(in_type, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
                           in_imm);
      @(posedge clk);
      #1;
      total += 2;
      if (out_instr !== exp_w[31:0]) begin
        bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, out_instr, exp_w[31:0]);
      end
      if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    total += 2;
    if (enc_count !== 4'd4) begin bad++; $display("FAIL stream_enc got=%0d exp=4", enc_count); end
    if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_idle got=%b exp=0", out_valid); end
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    total++;
    if (enc_count !== '0) begin bad++; $display("FAIL stream_clr got=%0d exp=0", enc_count); end
  endtask

  task automatic test_wrap_saturate();
    drain_and_clear();
    set_req(2'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 64'd4096);
    repeat (17) @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    total += 2;
    if (enc_count !== 4'd1) begin bad++; $display("FAIL wrap_enc got=%0d exp=1", enc_count); end
    if (err_count !== 4'd15) begin bad++; $display("FAIL sat_errc got=%0d exp=15", err_count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    set_req(2'd0, 7'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total += 3;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", out_valid); end
    if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_mid_instr got=%h exp=0", out_instr); end
    if (enc_count !== '0) begin bad++; $display("FAIL rst_mid_enc got=%0d exp=0", enc_count); end
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_type   = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: in_opcode = 7'b0000011;
        1: in_opcode = 7'b0010011;
        default: in_opcode = 7'b1100111;
      endcase
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_imm    = rand_imm(in_type);
      #1;
      total++;
      if (in_ready !== (!m_valid || out_ready)) begin
        bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, !m_valid || out_ready);
      end
      @(posedge clk);
      #1;
      total += 3;
      if (out_valid !== m_valid) begin
        bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, m_valid);
      end
      if (m_valid && (out_instr !== m_instr || out_err !== m_err)) begin
        bad++; $display("FAIL rnd_word[%0d] got=%h/%b exp=%h/%b", i, out_instr, out_err, m_instr, m_err);
      end
      if (int'(enc_count) != m_enc || int'(err_count) != m_errc) begin
        bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, enc_count, err_count, m_enc, m_errc);
      end
    end
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    set_req(2'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 64'd0);
    in_valid  = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    test_reset();
    test_directed();
    test_err_count();
    test_stall();
    test_back_to_back();
    test_wrap_saturate();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
